sram_read_arbiter: RTL
======================

# sram_read_arbiter

Shares the single read port of one `sram` instance (input, weight or output memory) among `NUM_REQ` fetch engines inside `MyDesign`. Uses round-robin arbitration and issues one read per cycle. Tracks which requester owns each in-flight read and routes the returned word back as a per-requester response strobe. It sits between the engine-side request ports and the `dut_*_read_address` / `*_dut_read_data` pins of the design.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 12: SRAM address width.
- `DATA_WIDTH`, 16: SRAM data width.
- `MAX_BURST`, 8: maximum consecutive grants to one requester. Used only with `SRAM_ARB_BURST_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant. A request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  one-hot-or-zero strobe: read data for requester i is present on `rsp_data`.
- `rsp_data`  out  DATA_WIDTH  returned word, broadcast to all requesters.
- `sram_read_address`  out  ADDR_WIDTH  registered address to the SRAM read port.
- `sram_read_data`  in  DATA_WIDTH  SRAM read data. Valid one cycle after the address is presented.
- `arb_idle`  out  1  high when no request is pending and no read is in flight.

## Operation
- Grant is combinational from `req_valid` and the rotating priority pointer `ptr`.
  - Priority order is ptr, ptr+1, …, wrapping mod NUM_REQ.
  - At most one `req_ready` bit is high, and only when the matching `req_valid` bit is high.
- On accept of requester g: `sram_read_address <= req_addr[g]` and `tag_q1 <= g`, with `vld_q1 <= 1`.
- The response pipeline has two stages: (vld_q1, tag_q1) moves to (vld_q2, tag_q2) every cycle.
  - `rsp_valid = vld_q2 ? onehot(tag_q2) : 0`.
  - `rsp_data = sram_read_data`, passed through combinationally.
- Pointer update without burst: after any accept by g, `ptr <= (g+1) mod NUM_REQ`. With no accept, `ptr` holds.
- When no request is accepted, `sram_read_address` holds its value and `vld_q1 <= 0`.
- Responses are never stalled; requesters must always be able to take `rsp_valid`.
- A requester may keep `req_valid` high across cycles. Each accept issues one read; the address may change every cycle.
- `arb_idle = ~|req_valid & ~vld_q1 & ~vld_q2`.
- Reset values (asynchronous):
  - `ptr` = 0, so requester 0 has highest priority.
  - `sram_read_address` = 0.
  - vld_q1, vld_q2, tags = 0, so `rsp_valid` = 0.
  - `arb_idle` = 1 while `req_valid` is 0.
  - `req_ready` = 0 while reset is asserted; the grant logic is gated by `~reset`.
- Reset asserted mid-operation drops all in-flight reads; no `rsp_valid` is produced for them.

## Timing
- Accept in cycle c.
- `sram_read_address` = that address in cycle c+1.
- `rsp_valid` and `rsp_data` are valid in cycle c+2, giving fixed latency 2.
- Throughput is one read per cycle, sustained across any mix of requesters.
- Simultaneous requests: only one is granted per cycle, and the others wait. Worst-case wait without burst is NUM_REQ-1 cycles.
- A request that deasserts `req_valid` before being granted is simply not issued; there is no penalty.

## Configuration
- `SRAM_ARB_BURST_EN` defined: burst lock.
  - After requester g is granted, it keeps the grant while `req_valid[g]` stays high, up to MAX_BURST consecutive accepts.
  - `ptr` advances to g+1 when g drops `req_valid` or the burst counter reaches MAX_BURST. The counter then resets to 0.
  - Counter width is $clog2(MAX_BURST+1).
- Not defined: no burst counter. `ptr` advances after every accept, giving strict per-beat round-robin.

## Structure
- Package `sram_arb_pkg` contains:
  - default `ADDR_WIDTH` and `DATA_WIDTH` localparams;
  - `tag_t` typedef: logic [$clog2(NUM_REQ_MAX)-1:0] with `NUM_REQ_MAX` = 8;
  - function `onehot(tag_t)`.
- Sub-module `rr_priority_pick`: purely combinational rotate-priority first-one finder.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `grant` and encoded `grant_idx`.
  - The top module holds all registers.

## Test plan
- Reset/idle: assert `reset` for 3 cycles, then release with all `req_valid` low. Expect `req_ready` = 0, `rsp_valid` = 0, `sram_read_address` = 0, `arb_idle` = 1.
- Single requester streaming: requester 2 requests addresses 0x010..0x013 on consecutive cycles, with SRAM word = address + 0x100.
  - `rsp_valid[2]` is high for 4 consecutive cycles, each exactly 2 cycles after its accept.
  - `rsp_data` = 0x110..0x113, in order.
- Full contention, macro off: all 4 requesters hold `req_valid` for 8 cycles. Grants are 0,1,2,3,0,1,2,3, and `rsp_valid` tags follow the same order delayed by 2 cycles.
- Burst lock, macro on, MAX_BURST = 3: requesters 0 and 1 are held high. Grants are 0,0,0,1,1,1,0,…
- Early release, macro on: requester 0 drops after 2 grants. The next cycle's grant goes to requester 1, and the counter restarts.
- Reset mid-flight: assert `reset` in the cycle after an accept. No `rsp_valid` appears in the following 3 cycles, `ptr` returns to 0, and the next grant with all requesting goes to requester 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and defaults for the SRAM read-port arbiter.
//   SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH : default SRAM geometry
//   NUM_REQ_MAX                       : largest supported requester count
//   tag_t                             : requester index carried down the pipe
//   onehot()                          : tag -> one-hot requester strobe
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int SRAM_ADDR_WIDTH = 12;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int NUM_REQ_MAX     = 8;
    localparam int TAG_W           = $clog2(NUM_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    function automatic logic [NUM_REQ_MAX-1:0] onehot(input tag_t tag);
        logic [NUM_REQ_MAX-1:0] v;
        v      = '0;
        v[tag] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority first-one finder. Requester ptr has the
// highest priority, then ptr+1, ... wrapping modulo NUM_REQ.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  tag_t    index of highest-priority requester (< NUM_REQ)
//   grant     out NUM_REQ  one-hot-or-zero winner
//   grant_idx out tag_t    encoded winner (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_priority_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  tag_t               ptr,
    output logic [NUM_REQ-1:0] grant,
    output tag_t               grant_idx
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] search;

    // Requests at or above ptr win first; if there are none, the wrapped
    // portion (below ptr) is searched, which is simply the full vector.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (i >= int'(ptr));
        end
        upper_req = req & upper_mask;
        search    = (|upper_req) ? upper_req : req;
    end

    // Descending scan so the lowest set bit of the search vector wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (search[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = tag_t'(i);
            end
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// -----------------------------------------------------------------------------
// sram_read_arbiter
// Round-robin share of one SRAM read port among NUM_REQ fetch engines. One
// read issued per cycle, fixed two-cycle latency, responses routed back by a
// tag travelling alongside the read.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   req_valid/req_addr  per-requester request and packed addresses
//   req_ready           one-hot-or-zero grant (accept = valid & ready)
//   rsp_valid/rsp_data  one-hot response strobe, broadcast read data
//   sram_read_address   registered SRAM read address
//   sram_read_data      SRAM data, valid one cycle after the address
//   arb_idle            no pending request and nothing in flight
//
// Build option: define SRAM_ARB_BURST_EN to let a granted requester keep the
// port for up to MAX_BURST consecutive accepts while it keeps requesting.
// -----------------------------------------------------------------------------
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         sram_read_address,
    input  logic [DATA_WIDTH-1:0]         sram_read_data,
    output logic                          arb_idle
);

    localparam int STAGES = 2;

    tag_t                               ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
    logic [STAGES:1]                    vld_pipe_q;
    tag_t [STAGES:1]                    tag_pipe_q;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0]                 pick_req;
    logic [NUM_REQ-1:0]                 grant;
    tag_t                               grant_idx;
    logic                               accept;
    logic [ADDR_WIDTH-1:0]              addr_sel;
    logic [NUM_REQ_MAX-1:0]             rsp_oh_full;
    logic                               unused_sink;

    function automatic tag_t wrap_inc(input tag_t t);
        return (int'(t) == NUM_REQ - 1) ? tag_t'(0) : t + tag_t'(1);
    endfunction

    // ---------------------------------------------------------------- grant
    // No grant can escape while reset is held.
    assign pick_req = reset ? '0 : req_valid;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (pick_req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign addr_arr  = req_addr;

    // AND-OR mux on the one-hot grant.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) addr_sel |= addr_arr[i];
        end
        addr_d = accept ? addr_sel : addr_q;
    end

    // ------------------------------------------------------ pointer update
`ifdef SRAM_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    int               beats;

    // While bursting, ptr parks on the owner so the picker keeps choosing it.
    // cnt_q counts the owner's consecutive accepts; a grant to anyone else
    // starts a fresh burst at 1.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        beats = 0;
        if (accept) begin
            beats = ((grant_idx == ptr_q) ? int'(cnt_q) : 0) + 1;
            if (beats >= MAX_BURST) begin
                ptr_d = wrap_inc(grant_idx);
                cnt_d = '0;
            end else begin
                ptr_d = grant_idx;
                cnt_d = CNT_W'(beats);
            end
        end else if (cnt_q != '0) begin
            // Owner dropped its request with nobody else asking: release.
            ptr_d = wrap_inc(ptr_q);
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    always_comb begin
        ptr_d = accept ? wrap_inc(grant_idx) : ptr_q;
    end
`endif

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            addr_q        <= addr_d;
            vld_pipe_q    <= {vld_pipe_q[1], accept};
            tag_pipe_q[1] <= accept ? grant_idx : tag_pipe_q[1];
            tag_pipe_q[2] <= tag_pipe_q[1];
        end
    end

    // ------------------------------------------------------------- outputs
    assign sram_read_address = addr_q;
    assign rsp_oh_full       = onehot(tag_pipe_q[2]);
    assign rsp_valid         = vld_pipe_q[2] ? rsp_oh_full[NUM_REQ-1:0] : '0;
    assign rsp_data          = sram_read_data;
    assign arb_idle          = ~|req_valid & ~vld_pipe_q[1] & ~vld_pipe_q[2];

    // Upper one-hot bits beyond NUM_REQ and MAX_BURST (default build) are
    // intentionally dropped.
    assign unused_sink = ^{rsp_oh_full, (MAX_BURST > 0)};

endmodule
